// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmitter, its FIFO-side
// interface and the bit-period counter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// First-word-fall-through read port between the transmit FIFO and the
// serialiser. The FIFO side is the master (it owns the data), the
// transmitter is the slave (it only pops).
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_fifo_empty;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_fifo_rd_en;

  modport master (
    output tx_fifo_empty,
    output tx_data,
    input  tx_fifo_rd_en
  );

  modport slave (
    input  tx_fifo_empty,
    input  tx_data,
    output tx_fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts clock cycles inside one serial bit and flags
// the last cycle of the bit. Written to be reused by the receiver.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Only meaningful while a bit is being timed; idle never reports an edge.
  assign bit_end = run && (cnt_q == LAST);

  // Next count: clear restarts a bit period, otherwise wrap at the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from a FWFT FIFO. Each popped byte is sent as a
// start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop
// bits. A byte waiting at the end of the last stop bit is chained on with
// no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tx_en,
  uart_tx_if.slave        fifo,
  output logic            tx_out,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0);

  tx_state_t            state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 parity_q,   parity_d;
  logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_out_q,   tx_out_d;
  logic                 busy_q,     busy_d;

  logic bit_end;
  logic last_stop;
  logic load;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .run    (state_q != IDLE),
    .bit_end(bit_end)
  );

  // Reset outranks a pending pop so a byte is never lost to a reset cycle.
  assign last_stop = (state_q == STOP) && bit_end && (stop_idx_q == STOP_LAST);
  assign load      = !reset && tx_en && !fifo.tx_fifo_empty &&
                     ((state_q == IDLE) || last_stop);

  assign fifo.tx_fifo_rd_en = load;
  assign tx_done            = !reset && last_stop;
  assign tx_out             = tx_out_q;
  assign tx_busy            = busy_q;

  // Frame sequencing: loading a byte wins over every bit-end transition.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_out_d   = tx_out_q;
    busy_d     = busy_q;
    if (load) begin
      shift_d  = fifo.tx_data;
      parity_d = (^fifo.tx_data) ^ ODD_BIT;
      state_d  = START;
      tx_out_d = 1'b0;
      busy_d   = 1'b1;
    end else if (bit_end) begin
      case (state_q)
        START: begin
          state_d   = DATA;
          tx_out_d  = shift_q[0];
          bit_idx_d = '0;
        end
        DATA: begin
          if (bit_idx_q != LAST_IDX) begin
            shift_d   = shift_q >> 1;
            tx_out_d  = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end else if (PARITY_EN != 0) begin
            state_d  = PARITY;
            tx_out_d = parity_q;
          end else begin
            state_d    = STOP;
            tx_out_d   = 1'b1;
            stop_idx_d = 1'b0;
          end
        end
        PARITY: begin
          state_d    = STOP;
          tx_out_d   = 1'b1;
          stop_idx_d = 1'b0;
        end
        STOP: begin
          if (stop_idx_q != STOP_LAST) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and line registers; the byte/parity holding registers need no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
    end
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even parity/1 stop,
// odd parity/2 stops) at 4 clocks per bit, each fed by a queue-based FIFO.
// A frame-level model predicts line, busy, done and pop for every cycle.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int PEN [3] = '{0, 1, 1};
  localparam int PODD[3] = '{0, 0, 1};
  localparam int STB [3] = '{1, 1, 2};

  typedef struct packed {
    logic out, busy, done, rd;
    logic eo, eb, ed, er;
  } smp_t;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       en    [3];
  logic       empty [3];
  logic [7:0] data  [3];
  logic       rd_w  [3];
  logic       out_w [3];
  logic       busy_w[3];
  logic       done_w[3];

  logic [7:0] fq [3][$];
  smp_t       lg [3][$];
  int         cl [3];
  bit         fbits[3][12];
  int         tests = 0;
  int         fails = 0;

  always #5 clock = ~clock;

  uart_tx_if fif0 ();
  uart_tx_if fif1 ();
  uart_tx_if fif2 ();

  assign fif0.tx_fifo_empty = empty[0];
  assign fif0.tx_data       = data[0];
  assign rd_w[0]            = fif0.tx_fifo_rd_en;
  assign fif1.tx_fifo_empty = empty[1];
  assign fif1.tx_data       = data[1];
  assign rd_w[1]            = fif1.tx_fifo_rd_en;
  assign fif2.tx_fifo_empty = empty[2];
  assign fif2.tx_data       = data[2];
  assign rd_w[2]            = fif2.tx_fifo_rd_en;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(rst), .tx_en(en[0]), .fifo(fif0),
    .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clock(clock), .reset(rst), .tx_en(en[1]), .fifo(fif1),
    .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clock(clock), .reset(rst), .tx_en(en[2]), .fifo(fif2),
    .tx_out(out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  function automatic int flen(int i);
    return (9 + PEN[i] + STB[i]) * CPB;
  endfunction

  // Frame as a list of line levels: start, data LSB first, parity, stops.
  task automatic build(int i, logic [7:0] b);
    int n;
    fbits[i][0] = 1'b0;
    for (int k = 0; k < 8; k++) fbits[i][1+k] = b[k];
    n = 9;
    if (PEN[i] != 0) begin
      // even parity makes the total count of ones even, odd makes it odd
      fbits[i][n] = (PODD[i] != 0) ? ~(^b) : (^b);
      n++;
    end
    for (int s = 0; s < STB[i]; s++) fbits[i][n+s] = 1'b1;
  endtask

  task automatic refresh(int i);
    empty[i] = (fq[i].size() == 0);
    data[i]  = empty[i] ? 8'($urandom) : fq[i][0];
  endtask

  task automatic push(int i, logic [7:0] b);
    fq[i].push_back(b);
    refresh(i);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) lg[i].delete();
  endtask

  // Advance n cycles, logging observed outputs and model predictions.
  task automatic run(int n);
    bit ld[3];
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        smp_t s;
        s.out  = out_w[i];
        s.busy = busy_w[i];
        s.done = done_w[i];
        s.rd   = rd_w[i];
        s.er   = !rst && en[i] && !empty[i] && (cl[i] <= 1);
        s.ed   = !rst && (cl[i] == 1);
        s.eb   = (cl[i] > 0);
        s.eo   = (cl[i] > 0) ? fbits[i][(flen(i) - cl[i]) / CPB] : 1'b1;
        ld[i]  = s.er;
        lg[i].push_back(s);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (rst) cl[i] = 0;
        else if (ld[i]) begin
          build(i, data[i]);
          cl[i] = flen(i);
        end else if (cl[i] > 0) cl[i]--;
      end
      for (int i = 0; i < 3; i++) begin
        if (lg[i][$].rd && fq[i].size() > 0) begin
          void'(fq[i].pop_front());
          refresh(i);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) en[i] = 1'b1;
    push(0, 8'h33);
    clear_logs();
    run(3);
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < lg[i].size(); c++) begin
        tests++;
        if ({lg[i][c].out, lg[i][c].busy, lg[i][c].done, lg[i][c].rd} !==
            {lg[i][c].eo, lg[i][c].eb, lg[i][c].ed, lg[i][c].er}) begin
          fails++;
          $display("FAIL reset_trace u%0d cyc %0d: out/busy/done/rd=%b required %b", i, c,
            {lg[i][c].out, lg[i][c].busy, lg[i][c].done, lg[i][c].rd},
            {lg[i][c].eo, lg[i][c].eb, lg[i][c].ed, lg[i][c].er});
        end
      end
    tests++;
    if (fq[0].size() != 1) begin
      fails++;
      $display("FAIL reset_no_pop: fifo depth %0d required 1", fq[0].size());
    end
    fq[0].delete();
    refresh(0);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int k, d, nrd;
    logic [9:0] pat;
    pat = 10'b1101001010;
    en[0] = 1'b1; en[1] = 1'b0; en[2] = 1'b0;
    push(0, 8'hA5);
    clear_logs();
    run(50);
    k = -1; d = -1; nrd = 0;
    for (int c = 0; c < lg[0].size(); c++) begin
      tests++;
      if ({lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd} !==
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er}) begin
        fails++;
        $display("FAIL single_trace cyc %0d: out/busy/done/rd=%b required %b", c,
          {lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd},
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er});
      end
      if (lg[0][c].rd === 1'b1) begin nrd++; if (k < 0) k = c; end
      if (lg[0][c].done === 1'b1 && d < 0) d = c;
    end
    tests++;
    if (nrd != 1) begin fails++; $display("FAIL single_pops: %0d pops required 1", nrd); end
    if (k >= 0) begin
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < CPB; c++) begin
          tests++;
          if (lg[0][k+1+b*CPB+c].out !== pat[b]) begin
            fails++;
            $display("FAIL single_wave bit %0d clk %0d: line %b required %b", b, c,
              lg[0][k+1+b*CPB+c].out, pat[b]);
          end
        end
    end
    tests++;
    if (k < 0 || d - k != 40) begin
      fails++;
      $display("FAIL single_done_cycle: done at frame cycle %0d required 40", d - k);
    end else begin
      tests++;
      if (lg[0][d+1].busy !== 1'b0) begin
        fails++;
        $display("FAIL single_busy_fall: busy %b required 0", lg[0][d+1].busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r[$];
    int dn[$];
    int nb;
    push(0, 8'h3C);
    push(0, 8'hFF);
    clear_logs();
    run(90);
    nb = 0;
    for (int c = 0; c < lg[0].size(); c++) begin
      tests++;
      if ({lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd} !==
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er}) begin
        fails++;
        $display("FAIL b2b_trace cyc %0d: out/busy/done/rd=%b required %b", c,
          {lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd},
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er});
      end
      if (lg[0][c].rd === 1'b1) r.push_back(c);
      if (lg[0][c].done === 1'b1) dn.push_back(c);
      if (lg[0][c].busy === 1'b1) nb++;
    end
    tests++;
    if (r.size() != 2 || dn.size() < 1) begin
      fails++;
      $display("FAIL b2b_pops: %0d pops %0d dones required 2 pops", r.size(), dn.size());
    end else begin
      tests++;
      if (r[1] != dn[0]) begin
        fails++;
        $display("FAIL b2b_chain: second pop at %0d required %0d", r[1], dn[0]);
      end
      tests++;
      if (lg[0][r[1]+1].out !== 1'b0 || lg[0][r[1]+1].busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_start: line/busy %b%b required 01", lg[0][r[1]+1].out,
          lg[0][r[1]+1].busy);
      end
      tests++;
      if (lg[0][r[0]+80].busy !== 1'b1 || lg[0][r[0]+81].busy !== 1'b0) begin
        fail_busy_edge(r[0]);
      end
    end
    tests++;
    if (nb != 80) begin fails++; $display("FAIL b2b_busy_len: %0d cycles required 80", nb); end
  endtask

  task automatic fail_busy_edge(int base);
    fails++;
    $display("FAIL b2b_busy_span: busy at +80/+81 = %b%b required 10",
      lg[0][base+80].busy, lg[0][base+81].busy);
  endtask

  task automatic test_parity();
    int k1, k2, d1, d2;
    en[0] = 1'b0; en[1] = 1'b1; en[2] = 1'b1;
    push(1, 8'h07);
    push(2, 8'h07);
    clear_logs();
    run(60);
    k1 = -1; k2 = -1; d1 = -1; d2 = -1;
    for (int i = 1; i < 3; i++)
      for (int c = 0; c < lg[i].size(); c++) begin
        tests++;
        if ({lg[i][c].out, lg[i][c].busy, lg[i][c].done, lg[i][c].rd} !==
            {lg[i][c].eo, lg[i][c].eb, lg[i][c].ed, lg[i][c].er}) begin
          fails++;
          $display("FAIL parity_trace u%0d cyc %0d: out/busy/done/rd=%b required %b", i, c,
            {lg[i][c].out, lg[i][c].busy, lg[i][c].done, lg[i][c].rd},
            {lg[i][c].eo, lg[i][c].eb, lg[i][c].ed, lg[i][c].er});
        end
      end
    for (int c = 0; c < 60; c++) begin
      if (lg[1][c].rd === 1'b1 && k1 < 0) k1 = c;
      if (lg[2][c].rd === 1'b1 && k2 < 0) k2 = c;
      if (lg[1][c].done === 1'b1 && d1 < 0) d1 = c;
      if (lg[2][c].done === 1'b1 && d2 < 0) d2 = c;
    end
    tests++;
    if (k1 < 0 || k2 < 0) begin
      fails++;
      $display("FAIL parity_pop: pop index %0d/%0d required >=0", k1, k2);
    end else begin
      for (int c = 0; c < CPB; c++) begin
        tests++;
        if (lg[1][k1+37+c].out !== 1'b1) begin
          fails++;
          $display("FAIL parity_even: bit %b required 1", lg[1][k1+37+c].out);
        end
        tests++;
        if (lg[2][k2+37+c].out !== 1'b0) begin
          fails++;
          $display("FAIL parity_odd: bit %b required 0", lg[2][k2+37+c].out);
        end
      end
      tests++;
      if (d1 - k1 != 44) begin fails++; $display("FAIL parity_len1: %0d required 44", d1 - k1); end
      tests++;
      if (d2 - k2 != 48) begin fails++; $display("FAIL parity_len2: %0d required 48", d2 - k2); end
    end
    en[1] = 1'b0; en[2] = 1'b0;
  endtask

  task automatic test_empty();
    int bad;
    for (int i = 0; i < 3; i++) en[i] = 1'b1;
    clear_logs();
    run(100);
    bad = 0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < lg[i].size(); c++)
        if (lg[i][c].rd !== 1'b0 || lg[i][c].out !== 1'b1 || lg[i][c].busy !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL empty_idle: %0d bad cycles required 0", bad); end
    en[1] = 1'b0; en[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int np;
    en[0] = 1'b1;
    push(0, 8'h55);
    push(0, 8'h81);
    clear_logs();
    run(18);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(45);
    for (int c = 0; c < lg[0].size(); c++) begin
      tests++;
      if ({lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd} !==
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er}) begin
        fails++;
        $display("FAIL rstmid_trace cyc %0d: out/busy/done/rd=%b required %b", c,
          {lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd},
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er});
      end
    end
    tests++;
    if ({lg[0][19].out, lg[0][19].busy, lg[0][19].rd} !== 3'b100) begin
      fails++;
      $display("FAIL rstmid_after: out/busy/rd=%b required 100",
        {lg[0][19].out, lg[0][19].busy, lg[0][19].rd});
    end
    np = 0;
    for (int c = 18; c < 20; c++) if (lg[0][c].rd === 1'b1) np++;
    tests++;
    if (np != 0) begin fails++; $display("FAIL rstmid_pop: %0d pops in reset required 0", np); end
    tests++;
    if (lg[0][20].rd !== 1'b1 || lg[0][60].done !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_restart: rd %b done %b required 11", lg[0][20].rd, lg[0][60].done);
    end
  endtask

  task automatic test_en_drop();
    int np;
    en[0] = 1'b1;
    push(0, 8'h5A);
    push(0, 8'h12);
    clear_logs();
    run(2);
    en[0] = 1'b0;
    run(60);
    np = 0;
    for (int c = 0; c < lg[0].size(); c++) begin
      tests++;
      if ({lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd} !==
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er}) begin
        fails++;
        $display("FAIL endrop_trace cyc %0d: out/busy/done/rd=%b required %b", c,
          {lg[0][c].out, lg[0][c].busy, lg[0][c].done, lg[0][c].rd},
          {lg[0][c].eo, lg[0][c].eb, lg[0][c].ed, lg[0][c].er});
      end
      if (lg[0][c].rd === 1'b1) np++;
    end
    tests++;
    if (np != 1 || fq[0].size() != 1) begin
      fails++;
      $display("FAIL endrop_pops: %0d pops depth %0d required 1 pop depth 1", np, fq[0].size());
    end
    tests++;
    if (lg[0][40].done !== 1'b1 || lg[0][61].busy !== 1'b0) begin
      fails++;
      $display("FAIL endrop_complete: done %b busy %b required 1 0", lg[0][40].done,
        lg[0][61].busy);
    end
    en[0] = 1'b1;
    run(45);
  endtask

  task automatic test_random();
    clear_logs();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        en[i] = ($urandom_range(0, 15) != 0);
        if (fq[i].size() < 3 && $urandom_range(0, 20) == 0) push(i, 8'($urandom));
      end
      rst = ($urandom_range(0, 399) == 0);
      run(1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < lg[i].size(); c++) begin
        tests++;
        if ({lg[i][c].out, lg[i][c].busy, lg[i][c].done, lg[i][c].rd} !==
            {lg[i][c].eo, lg[i][c].eb, lg[i][c].ed, lg[i][c].er}) begin
          fails++;
          $display("FAIL random_trace u%0d cyc %0d: out/busy/done/rd=%b required %b", i, c,
            {lg[i][c].out, lg[i][c].busy, lg[i][c].done, lg[i][c].rd},
            {lg[i][c].eo, lg[i][c].eb, lg[i][c].ed, lg[i][c].er});
        end
      end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      cl[i] = 0;
      refresh(i);
    end
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_empty();
    test_reset_mid();
    test_en_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
